// File: rtl/arch_defs_pkg.sv
// Shared UART architecture definitions: data width, RX FSM encoding,
// register offsets, and the command/status bit positions of the register file.
package arch_defs_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    // RX state encoding; RESET and INIT are kept for encoding compatibility only.
    typedef enum logic [2:0] {
        S_UART_RX_RESET          = 3'd0,
        S_UART_RX_INIT           = 3'd1,
        S_UART_RX_IDLE           = 3'd2,
        S_UART_RX_VALIDATE_START = 3'd3,
        S_UART_RX_READ_DATA      = 3'd4,
        S_UART_RX_STOP           = 3'd5
    } uart_fsm_state_t;

    // Byte offsets of the UART register file.
    typedef enum logic [3:0] {
        UART_REG_DATA    = 4'h0,
        UART_REG_STATUS  = 4'h4,
        UART_REG_COMMAND = 4'h8,
        UART_REG_BAUD    = 4'hC
    } uart_reg_offset_e;

    // Bit position of the clear-errors request in UART_REG_COMMAND.
    localparam int unsigned UART_CMD_CLEAR_ERR_BIT = 0;

    // Bit positions in UART_REG_STATUS.
    localparam int unsigned UART_STATUS_RX_READY  = 0;
    localparam int unsigned UART_STATUS_FRAME_ERR = 1;
    localparam int unsigned UART_STATUS_OVERRUN   = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals crossing into the clk domain.
// Ports: clk, reset_n (async, active-low), d (async input), q (synchronised).
// RESET_VAL sets the value both stages take during reset.
module sync_2ff #(
    parameter int unsigned WIDTH     = 1,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= {WIDTH{RESET_VAL}};
            q    <= {WIDTH{RESET_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the RX pin, de-frames LSB-first characters,
// holds one byte until acknowledged, and flags framing errors and overruns.
// Ports: clk, reset_n (async, active-low), rx_serial_in (raw pin),
// rx_read_ack / clear_errors (one-cycle pulses from the register file),
// rx_data_out, rx_data_ready, rx_frame_error, rx_overrun, rx_busy.
module uart_receiver
    import arch_defs_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 20_000_000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_serial_in,
    input  logic                  rx_read_ack,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_ready,
    output logic                  rx_frame_error,
    output logic                  rx_overrun,
    output logic                  rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX      = 3'(DATA_WIDTH - 1);

    logic                  rx_sync;
    uart_fsm_state_t       state, state_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [2:0]            bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  ready_next, frame_err_next, overrun_next, busy_next;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_serial_in),
        .q       (rx_sync)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_UART_RX_IDLE;
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            rx_data_out    <= '0;
            rx_data_ready  <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_overrun     <= 1'b0;
            rx_busy        <= 1'b0;
        end else begin
            state          <= state_next;
            bit_cnt        <= bit_cnt_next;
            bit_idx        <= bit_idx_next;
            shift          <= shift_next;
            rx_data_out    <= data_next;
            rx_data_ready  <= ready_next;
            rx_frame_error <= frame_err_next;
            rx_overrun     <= overrun_next;
            rx_busy        <= busy_next;
        end
    end

    // Next-state and output logic. Clears are applied first so a coincident set wins.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        data_next      = rx_data_out;
        ready_next     = rx_data_ready;
        frame_err_next = rx_frame_error;
        overrun_next   = rx_overrun;

        if (rx_read_ack) begin
            ready_next = 1'b0;
        end
        if (clear_errors) begin
            frame_err_next = 1'b0;
            overrun_next   = 1'b0;
        end

        case (state)
            S_UART_RX_IDLE: begin
                if (!rx_sync) begin
                    bit_cnt_next = HALF_BIT_LOAD;
                    state_next   = S_UART_RX_VALIDATE_START;
                end
            end

            S_UART_RX_VALIDATE_START: begin
                if (bit_cnt == '0) begin
                    if (!rx_sync) begin
                        bit_cnt_next = FULL_BIT_LOAD;
                        bit_idx_next = 3'd0;
                        state_next   = S_UART_RX_READ_DATA;
                    end else begin
                        state_next = S_UART_RX_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end
            end

            S_UART_RX_READ_DATA: begin
                if (bit_cnt == '0) begin
                    shift_next[bit_idx] = rx_sync;
                    bit_cnt_next        = FULL_BIT_LOAD;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = S_UART_RX_STOP;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end
            end

            S_UART_RX_STOP: begin
                // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
                if (bit_cnt == '0) begin
                    if (rx_sync) begin
                        if (!rx_data_ready || rx_read_ack) begin
                            data_next  = shift;
                            ready_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = S_UART_RX_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end
            end

            default: begin
                state_next = S_UART_RX_IDLE;
            end
        endcase

        busy_next = (state_next != S_UART_RX_IDLE);
    end

endmodule
